cmp_seq_ctrl: RTL and testbench
===============================

// Module: cmp_seq_ctrl
// PURPOSE
//  Sequencer for one shared magnitude-compare bit cell. Accepts an operand
//  pair (X, Y) over a valid/ready handshake and scans it one bit per cycle,
//  MSB first. Returns the G (X>Y) and L (X<Y) flags over a second valid/ready
//  handshake. It replaces the fully unrolled serial and tree comparators
//  wherever area matters more than latency.
// PARAMETERS
//  WIDTH       8   operand width in bits; must be >= 2
//  EARLY_EXIT  1   1: stop at the first differing bit; 0: always scan WIDTH bits
// PORTS
//  clk        in   1                    rising-edge clock
//  rst_n      in   1                    asynchronous active-low reset
//  in_valid   in   1                    operand pair valid
//  in_ready   out  1                    block can accept an operand pair
//  in_x       in   WIDTH                operand X (unsigned)
//  in_y       in   WIDTH                operand Y (unsigned)
//  out_valid  out  1                    result valid
//  out_ready  in   1                    consumer accepts the result
//  out_g      out  1                    X > Y
//  out_l      out  1                    X < Y
//  out_cycles out  $clog2(WIDTH+1)      number of SCAN cycles used
//  busy       out  1                    high in SCAN or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; in_ready=1.
//   - out_valid, out_g, out_l, out_cycles, busy = 0.
//   - Internal operand registers are cleared.
//  FSM states: IDLE, SCAN, DONE. All outputs are registered or decoded from state.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&in_ready: capture in_x/in_y, idx<=WIDTH-1, g<=0, l<=0,
//     cnt<=0, then go to SCAN.
//  SCAN (in_ready=0), one bit per cycle:
//   - cnt<=cnt+1.
//   - If x[idx]&~y[idx], set g. If ~x[idx]&y[idx], set l.
//   - Once g or l is set it is locked; later bits never change it.
//   - EARLY_EXIT=1 and a difference is found -> go to DONE this cycle.
//   - Otherwise, idx==0 -> go to DONE; else idx<=idx-1.
//  DONE:
//   - out_valid=1. out_g, out_l and out_cycles are held stable while out_valid=1.
//   - On out_valid&out_ready -> IDLE, and out_valid drops the next cycle.
//   - in_ready is not asserted in the same cycle as the out handshake, so
//     there is no overlap (1 idle cycle minimum between jobs).
//  Latency: operand accept at edge k, result visible after edge k+out_cycles.
//   - out_cycles ranges from 1 to WIDTH.
//   - out_cycles = position of the first differing bit from the MSB, +1.
//   - Equal operands: out_cycles=WIDTH.
//   - EARLY_EXIT=0: out_cycles=WIDTH always.
//  Invariants:
//   - out_g&out_l is never 1.
//   - Equal operands give out_g=out_l=0.
//   - Flags match unsigned X>Y / X<Y.
//  Boundary conditions:
//   - in_valid while busy: ignored (in_ready=0). The source must hold its data.
//   - out_ready held low: DONE is held indefinitely with outputs stable.
//   - rst_n low mid-SCAN or in DONE: the job is discarded and the FSM is in
//     IDLE immediately, with all outputs at reset values.
//   - idx never wraps; the SCAN exit at idx==0 has priority over the decrement.
//   - out_ready high outside DONE: no effect.
// TESTING
//  1. X=0xA5, Y=0x5A, EARLY_EXIT=1, out_ready=1 -> out_g=1, out_l=0,
//     out_cycles=1, out_valid 1 cycle after accept.
//  2. X=Y=0x3C -> out_g=0, out_l=0, out_cycles=8, out_valid 8 cycles after accept.
//  3. X=0x80, Y=0x81 -> out_l=1, out_g=0, out_cycles=8.
//     Same operands with EARLY_EXIT=0 -> identical flags, out_cycles=8.
//  4. Backpressure: X=0x10, Y=0x0F, out_ready low for 5 cycles in DONE
//     -> out_valid/out_g=1 held stable, in_ready=0.
//     Then raise out_ready -> IDLE, in_ready=1 next cycle.
//  5. Reset mid-scan: X=0x01, Y=0x00, pull rst_n low at SCAN cycle 4
//     -> out_valid=0, busy=0, in_ready=1 asynchronously.
//     A new pair X=0x02, Y=0x03 then gives out_l=1, out_cycles=8.
//  6. 1000 random pairs, random in_valid/out_ready gaps, both EARLY_EXIT values
//     -> flags equal unsigned compare, no lost or duplicated results,
//     out_cycles as defined.

Source files
------------

// File: rtl/cmp_seq_ctrl.sv
// Purpose: bit-serial magnitude compare of an operand pair, MSB first, one bit cell shared over time.
// Latency: result valid out_cycles edges after accept (1..WIDTH; WIDTH when EARLY_EXIT=0 or operands equal).
// Backpressure: in_ready low while busy; DONE holds flags and cycle count stable until out_ready.
module cmp_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_x,
  input  logic [WIDTH-1:0]           in_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_g,
  output logic                       out_l,
  output logic [$clog2(WIDTH+1)-1:0] out_cycles,
  output logic                       busy
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH+1);

  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [IW-1:0]    idx_q;
  logic             g_q;
  logic             l_q;
  logic [CW-1:0]    cnt_q;

  logic bit_x;
  logic bit_y;
  logic hit_g;
  logic hit_l;
  logic scan_exit;

  // Bit cell: compare the current bit; a flag already set blocks any later hit (lock).
  always_comb begin
    bit_x     = x_q[idx_q];
    bit_y     = y_q[idx_q];
    hit_g     = bit_x & ~bit_y & ~(g_q | l_q);
    hit_l     = ~bit_x & bit_y & ~(g_q | l_q);
    // Exit at idx 0 takes priority over the decrement, so idx never wraps.
    scan_exit = ((EARLY_EXIT != 0) && (hit_g || hit_l)) || (idx_q == '0);
  end

  // Sequencer state, operand capture, bit scan and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q     <= in_x;
            y_q     <= in_y;
            idx_q   <= IDX_MSB;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (hit_g) g_q <= 1'b1;
          if (hit_l) l_q <= 1'b1;
          if (scan_exit) begin
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q - IDX_ONE;
          end
        end
        ST_DONE: begin
          // Returning to IDLE only after the handshake keeps in_ready low in the
          // handshake cycle, giving at least one idle cycle between jobs.
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_g      = g_q;
  assign out_l      = l_q;
  assign out_cycles = cnt_q;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Testbench for cmp_seq_ctrl: lane 0 is EARLY_EXIT=0, lane 1 is EARLY_EXIT=1.
// Directed vector table, backpressure and mid-scan reset sequences, then random traffic on both lanes.
`timescale 1ns/1ps
module tb_cmp_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid   [2];
  logic       in_ready   [2];
  logic [7:0] in_x       [2];
  logic [7:0] in_y       [2];
  logic       out_valid  [2];
  logic       out_ready  [2];
  logic       out_g      [2];
  logic       out_l      [2];
  logic [3:0] out_cycles [2];
  logic       busy       [2];

  int errors;
  int checks;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       g;
    logic       l;
    int         cyc_ee;
  } vec_t;

  vec_t vecs [12];

  cmp_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_x(in_x[0]), .in_y(in_y[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_g(out_g[0]), .out_l(out_l[0]),
    .out_cycles(out_cycles[0]), .busy(busy[0])
  );

  cmp_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) dut_ee (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_x(in_x[1]), .in_y(in_y[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_g(out_g[1]), .out_l(out_l[1]),
    .out_cycles(out_cycles[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: cycles = 1 + position of first differing bit counted from the MSB.
  function automatic int model_cyc(input logic [7:0] x, input logic [7:0] y, input int ee);
    if (ee == 0) return 8;
    for (int i = 7; i >= 0; i--) begin
      if (x[i] != y[i]) return 8 - i;
    end
    return 8;
  endfunction

  // Present a pair and return at the first negedge after the accept edge.
  task automatic start_job(input int w, input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    @(negedge clk);
    in_x[w] = x;
    in_y[w] = y;
    in_valid[w] = 1'b1;
    while (!in_ready[w] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[w]) check("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid[w] = 1'b0;
  endtask

  // Count edges from accept until out_valid is first seen.
  task automatic wait_result(input int w, input bit rnd, output int lat);
    lat = 0;
    while (!out_valid[w] && lat < 40) begin
      if (rnd) out_ready[w] = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      lat++;
    end
    if (!out_valid[w]) check("result_timeout", 0, 1);
  endtask

  // Complete the output handshake, checking stability while stalled and the drop afterwards.
  task automatic consume(input int w, input bit rnd);
    logic       g0;
    logic       l0;
    logic [3:0] c0;
    int         n;
    bit         r;
    g0 = out_g[w];
    l0 = out_l[w];
    c0 = out_cycles[w];
    n  = 0;
    do begin
      r = (!rnd || n >= 4) ? 1'b1 : ($urandom_range(0, 1) == 1);
      out_ready[w] = r;
      @(negedge clk);
      n++;
      if (!r) begin
        check("hold_valid", out_valid[w], 1);
        check("hold_g", out_g[w], g0);
        check("hold_l", out_l[w], l0);
        check("hold_cycles", out_cycles[w], c0);
      end
    end while (!r);
    check("valid_drop", out_valid[w], 0);
    check("ready_after", in_ready[w], 1);
  endtask

  task automatic run_and_check(input int w, input logic [7:0] x, input logic [7:0] y,
                               input logic eg, input logic el, input int ecyc, input bit rnd);
    int lat;
    start_job(w, x, y);
    wait_result(w, rnd, lat);
    check("flag_g", out_g[w], eg);
    check("flag_l", out_l[w], el);
    check("out_cycles", out_cycles[w], ecyc);
    check("latency", lat, ecyc);
    consume(w, rnd);
  endtask

  task automatic run_random(input int w, input int n);
    logic [7:0] x;
    logic [7:0] y;
    int         gap;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      for (int j = 0; j < gap; j++) begin
        out_ready[w] = ($urandom_range(0, 1) == 1);
        @(negedge clk);
      end
      x = 8'($urandom);
      y = ($urandom_range(0, 7) == 0) ? x : 8'($urandom);
      run_and_check(w, x, y, (x > y), (x < y), model_cyc(x, y, w), 1'b1);
    end
  endtask

  initial begin
    int lat;
    errors = 0;
    checks = 0;

    vecs[0]  = '{x: 8'hA5, y: 8'h5A, g: 1'b1, l: 1'b0, cyc_ee: 1};
    vecs[1]  = '{x: 8'h3C, y: 8'h3C, g: 1'b0, l: 1'b0, cyc_ee: 8};
    vecs[2]  = '{x: 8'h80, y: 8'h81, g: 1'b0, l: 1'b1, cyc_ee: 8};
    vecs[3]  = '{x: 8'h10, y: 8'h0F, g: 1'b1, l: 1'b0, cyc_ee: 4};
    vecs[4]  = '{x: 8'h02, y: 8'h03, g: 1'b0, l: 1'b1, cyc_ee: 8};
    vecs[5]  = '{x: 8'hFF, y: 8'h00, g: 1'b1, l: 1'b0, cyc_ee: 1};
    vecs[6]  = '{x: 8'h00, y: 8'hFF, g: 1'b0, l: 1'b1, cyc_ee: 1};
    vecs[7]  = '{x: 8'h00, y: 8'h00, g: 1'b0, l: 1'b0, cyc_ee: 8};
    vecs[8]  = '{x: 8'h7F, y: 8'h80, g: 1'b0, l: 1'b1, cyc_ee: 1};
    vecs[9]  = '{x: 8'h40, y: 8'h41, g: 1'b0, l: 1'b1, cyc_ee: 8};
    vecs[10] = '{x: 8'hC8, y: 8'hC0, g: 1'b1, l: 1'b0, cyc_ee: 5};
    vecs[11] = '{x: 8'h01, y: 8'h00, g: 1'b1, l: 1'b0, cyc_ee: 8};

    rst_n = 1'b0;
    for (int w = 0; w < 2; w++) begin
      in_valid[w]  = 1'b0;
      in_x[w]      = 8'h00;
      in_y[w]      = 8'h00;
      out_ready[w] = 1'b1;
    end
    repeat (2) @(negedge clk);

    // Reset state on both lanes.
    for (int w = 0; w < 2; w++) begin
      check("rst_in_ready", in_ready[w], 1);
      check("rst_out_valid", out_valid[w], 0);
      check("rst_busy", busy[w], 0);
      check("rst_out_g", out_g[w], 0);
      check("rst_out_l", out_l[w], 0);
      check("rst_out_cycles", out_cycles[w], 0);
    end
    rst_n = 1'b1;

    // Directed vector table on both lanes.
    for (int i = 0; i < 12; i++) begin
      for (int w = 0; w < 2; w++) begin
        run_and_check(w, vecs[i].x, vecs[i].y, vecs[i].g, vecs[i].l,
                      (w == 1) ? vecs[i].cyc_ee : 8, 1'b0);
      end
    end

    // Backpressure: DONE held with out_ready low; a new in_valid meanwhile is ignored.
    out_ready[1] = 1'b0;
    start_job(1, 8'h10, 8'h0F);
    wait_result(1, 1'b0, lat);
    check("bp_latency", lat, 4);
    in_x[1] = 8'hFF;
    in_y[1] = 8'h00;
    in_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", out_valid[1], 1);
      check("bp_g", out_g[1], 1);
      check("bp_l", out_l[1], 0);
      check("bp_cycles", out_cycles[1], 4);
      check("bp_in_ready", in_ready[1], 0);
      check("bp_busy", busy[1], 1);
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid[1], 0);
    check("bp_release_ready", in_ready[1], 1);
    check("bp_release_busy", busy[1], 0);

    // Reset in SCAN cycle 4, checked before any clock edge.
    start_job(1, 8'h01, 8'h00);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy[1], 1);
    check("pre_rst_valid", out_valid[1], 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready[1], 1);
    check("mid_rst_busy", busy[1], 0);
    check("mid_rst_valid", out_valid[1], 0);
    check("mid_rst_g", out_g[1], 0);
    check("mid_rst_l", out_l[1], 0);
    check("mid_rst_cycles", out_cycles[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check(1, 8'h02, 8'h03, 1'b0, 1'b1, 8, 1'b0);

    // Random traffic with random gaps and stalls, both lanes concurrently.
    fork
      run_random(0, 500);
      run_random(1, 500);
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
